pa_horner_ctrl: RTL
===================

// Module: pa_horner_ctrl
// PURPOSE
//  Upstream sequencer for the privacy-amplification modular datapath (multiplier -> adder -> Barrett reducer).
//  Accepts a block of sifted/corrected key words and a hash seed r, then evaluates h_i = (h_{i-1}*r + k_i) mod q
//  by Horner's rule, h_0 = 0. It drives the arithmetic units and feeds each reduced result back as the accumulator.
//  The final 24-bit hash is presented once per block to the key-output stage.
// PARAMETERS
//  W         24         data/residue width
//  MULT_LAT  1          multiplier latency, cycles (>=1)
//  ADD_LAT   1          adder latency, cycles (>=1)
//  RED_LAT   1          reducer latency, cycles (>=1)
//  MODULUS   24'hFFFFFD reduction modulus q (used only by the optional check)
// PORTS
//  clk_100Mhz  in   1      system clock, all logic on rising edge
//  rst         in   1      asynchronous, active-high reset
//  start       in   1      1-cycle pulse: latch seed/block_len, begin block (ignored while busy)
//  seed        in   W      hash seed r
//  block_len   in   16     number of key words N in the block
//  key_data    in   W      key word k_i
//  key_valid   in   1      key_data valid
//  key_ready   out  1      controller accepts key_data this cycle
//  mult_a      out  W      multiplier operand A = accumulator
//  mult_b      out  W      multiplier operand B = latched seed
//  mult_p      in   2W     multiplier product
//  add_a       out  2W     adder operand A = mult_p
//  add_b       out  W      adder operand B = latched key word
//  add_ce      out  1      adder clock enable
//  add_s       in   2W+1   adder sum
//  red_in      out  2W+1   reducer input = add_s
//  red_out     in   W      reduced residue
//  hash_out    out  W      final hash, held until next block completes
//  hash_valid  out  1      1-cycle pulse: hash_out updated
//  busy        out  1      high from start acceptance until hash_valid cycle inclusive
// BEHAVIOUR
//  Reset: key_ready=0, add_ce=0, hash_valid=0, busy=0, hash_out=0, accumulator=0, seed reg=0, key reg=0, FSM=IDLE.
//  mult_a/mult_b/add_a/add_b/red_in are pure wires from registers/inputs; their reset value follows their source.
//  L = MULT_LAT+ADD_LAT+RED_LAT.
//  FSM: IDLE -start-> LOAD (acc<=0, seed/N latched, remaining<=N); if N==0, IDLE -start-> DONE.
//  LOAD: key_ready=1. Handshake (key_valid&key_ready) latches key_data and goes to MUL. key_valid low = stall, no timeout.
//  MUL: MULT_LAT cycles, operands held stable. Then ADD.
//  ADD: ADD_LAT cycles, add_ce=1 only here. Then RED.
//  RED: RED_LAT cycles. On the last cycle: acc<=red_out, remaining<=remaining-1.
//    Goes to DONE if remaining was 1, else to LOAD.
//  Word throughput: handshake at cycle t -> acc updated at the edge ending cycle t+L -> next key_ready at cycle t+L+1.
//  DONE: hash_out<=acc (0 when N==0), hash_valid=1 for exactly one cycle, busy still 1. Then IDLE.
//  start during LOAD/MUL/ADD/RED/DONE is ignored; seed and block_len are sampled only on an accepted start.
//  Width: the products and sums are carried at full width (2W, 2W+1) with no truncation before the reducer.
//  rst mid-block aborts immediately. There is no partial hash_valid, and the next start begins cleanly.
// CONFIGURATION
//  PA_RESIDUE_CHECK_EN defined: adds output red_err (1 bit, reset 0).
//    Sticky-set when red_out >= MODULUS is sampled at RED writeback. Cleared by rst or an accepted start.
//  Undefined: port and logic are absent; behaviour is otherwise identical.
// TESTING (bench with the functional mult/add/reducer units, reducer = low W bits)
//  seed=2, N=3, keys 1,2,3 at full rate -> one hash_valid, hash_out=11. Default latencies: 4 cycles per word.
//  N=0 start -> hash_valid 2 cycles after start, hash_out=0, key_ready never asserted.
//  seed=24'hFFFFFF, N=2, keys 5,7 -> hash_out=(5*24'hFFFFFF+7) mod 2^24 = 2.
//  key_valid held low 20 cycles in LOAD -> key_ready stays 1, add_ce stays 0, busy stays 1, no hash_valid.
//  rst asserted in ADD of word 2 -> all outputs 0 at once. Then new start seed=3, N=1, key=4 -> hash_out=4.
//  start pulsed mid-block with a different seed -> ignored, original hash result.
//  With PA_RESIDUE_CHECK_EN: force red_out=24'hFFFFFE -> red_err=1, stays set until the next start.

Source files
------------

// File: rtl/pa_horner_ctrl.sv
// Horner-rule sequencer for the privacy-amplification modular datapath: h_i = (h_{i-1}*r + k_i) mod q.
// Optional residue range check enabled by defining PA_RESIDUE_CHECK_EN (adds output red_err).
module pa_horner_ctrl #(
    parameter int             W        = 24,
    parameter int             MULT_LAT = 1,
    parameter int             ADD_LAT  = 1,
    parameter int             RED_LAT  = 1,
    parameter logic [W-1:0]   MODULUS  = 24'hFFFFFD
) (
    input  logic              clk_100Mhz,
    input  logic              rst,
    input  logic              start,
    input  logic [W-1:0]      seed,
    input  logic [15:0]       block_len,
    input  logic [W-1:0]      key_data,
    input  logic              key_valid,
    output logic              key_ready,
    output logic [W-1:0]      mult_a,
    output logic [W-1:0]      mult_b,
    input  logic [2*W-1:0]    mult_p,
    output logic [2*W-1:0]    add_a,
    output logic [W-1:0]      add_b,
    output logic              add_ce,
    input  logic [2*W:0]      add_s,
    output logic [2*W:0]      red_in,
    input  logic [W-1:0]      red_out,
    output logic [W-1:0]      hash_out,
    output logic              hash_valid,
    output logic              busy
`ifdef PA_RESIDUE_CHECK_EN
    ,
    output logic              red_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_MUL  = 3'd2,
        S_ADD  = 3'd3,
        S_RED  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [15:0] MULT_LAST = 16'(MULT_LAT - 1);
    localparam logic [15:0] ADD_LAST  = 16'(ADD_LAT - 1);
    localparam logic [15:0] RED_LAST  = 16'(RED_LAT - 1);

    state_t         state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [15:0]    remaining_q, remaining_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   seed_q, seed_d;
    logic [W-1:0]   key_q, key_d;
    logic [W-1:0]   hash_out_q, hash_out_d;
    logic           hash_valid_q, hash_valid_d;
    logic           key_ready_q, key_ready_d;
    logic           add_ce_q, add_ce_d;
    logic           busy_q, busy_d;
`ifdef PA_RESIDUE_CHECK_EN
    logic           red_err_q, red_err_d;
`else
    logic           unused_modulus_s;
    assign unused_modulus_s = ^MODULUS;
`endif

    // Datapath operands come straight from the holding registers so they stay stable per phase.
    assign mult_a     = acc_q;
    assign mult_b     = seed_q;
    assign add_a      = mult_p;
    assign add_b      = key_q;
    assign red_in     = add_s;
    assign key_ready  = key_ready_q;
    assign add_ce     = add_ce_q;
    assign hash_out   = hash_out_q;
    assign hash_valid = hash_valid_q;
    assign busy       = busy_q;
`ifdef PA_RESIDUE_CHECK_EN
    assign red_err    = red_err_q;
`endif

    // Next-state and next-output computation for the block sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        remaining_d  = remaining_q;
        acc_d        = acc_q;
        seed_d       = seed_q;
        key_d        = key_q;
        hash_out_d   = hash_out_q;
        hash_valid_d = 1'b0;
`ifdef PA_RESIDUE_CHECK_EN
        red_err_d    = red_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                // busy_q is still high in the hash_valid cycle, so a start there is dropped.
                if (start && !busy_q) begin
                    acc_d       = {W{1'b0}};
                    seed_d      = seed;
                    remaining_d = block_len;
                    cnt_d       = 16'd0;
                    state_d     = (block_len == 16'd0) ? S_DONE : S_LOAD;
`ifdef PA_RESIDUE_CHECK_EN
                    red_err_d   = 1'b0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (key_valid && key_ready_q) begin
                    key_d   = key_data;
                    cnt_d   = 16'd0;
                    state_d = S_MUL;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_MUL: begin
                if (cnt_q == MULT_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = S_ADD;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            S_ADD: begin
                if (cnt_q == ADD_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = S_RED;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            S_RED: begin
                if (cnt_q == RED_LAST) begin
                    acc_d       = red_out;
                    remaining_d = remaining_q - 16'd1;
                    cnt_d       = 16'd0;
                    state_d     = (remaining_q == 16'd1) ? S_DONE : S_LOAD;
`ifdef PA_RESIDUE_CHECK_EN
                    if (red_out >= MODULUS) begin
                        red_err_d = 1'b1;
                    end else begin
                        red_err_d = red_err_q;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                hash_out_d   = acc_q;
                hash_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        key_ready_d = (state_d == S_LOAD);
        add_ce_d    = (state_d == S_ADD);
        // Keep busy through the cycle in which hash_valid is presented.
        busy_d      = (state_d != S_IDLE) || (state_q == S_DONE);
    end

    // State and output registers; reset aborts any block in flight.
    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 16'd0;
            remaining_q  <= 16'd0;
            acc_q        <= {W{1'b0}};
            seed_q       <= {W{1'b0}};
            key_q        <= {W{1'b0}};
            hash_out_q   <= {W{1'b0}};
            hash_valid_q <= 1'b0;
            key_ready_q  <= 1'b0;
            add_ce_q     <= 1'b0;
            busy_q       <= 1'b0;
`ifdef PA_RESIDUE_CHECK_EN
            red_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            remaining_q  <= remaining_d;
            acc_q        <= acc_d;
            seed_q       <= seed_d;
            key_q        <= key_d;
            hash_out_q   <= hash_out_d;
            hash_valid_q <= hash_valid_d;
            key_ready_q  <= key_ready_d;
            add_ce_q     <= add_ce_d;
            busy_q       <= busy_d;
`ifdef PA_RESIDUE_CHECK_EN
            red_err_q    <= red_err_d;
`endif
        end
    end

endmodule
